// File: rtl/gcd_job_sched.sv
// gcd_job_sched: job FIFO, issue FSM and held response slot
// in front of the GCD core; zero-operand jobs are answered locally.
module gcd_job_sched #(
  parameter int W     = 16,
  parameter int TW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [W-1:0]  i_req_a,
  input  logic [W-1:0]  i_req_b,
  input  logic [TW-1:0] i_req_tag,
  output logic          o_resp_valid,
  input  logic          i_resp_ready,
  output logic [W-1:0]  o_resp_c,
  output logic [TW-1:0] o_resp_tag,
  output logic [CW-1:0] o_resp_cycles,
  output logic [15:0]   o_done_count,
  output logic          o_busy,
  output logic [W-1:0]  o_gcd_a,
  output logic [W-1:0]  o_gcd_b,
  output logic          o_gcd_in_valid,
  input  logic          i_gcd_in_ready,
  input  logic          i_gcd_out_valid,
  input  logic [W-1:0]  i_gcd_c
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e        state_q, state_d;

  logic [W-1:0]  fa_q [DEPTH];
  logic [W-1:0]  fb_q [DEPTH];
  logic [TW-1:0] ft_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  logic          full, empty;
  logic          push, pop;
  logic [W-1:0]  head_a, head_b;
  logic [TW-1:0] head_tag;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] cyc_inc;

  logic          rv_q, rv_d;
  logic [W-1:0]  rc_q, rc_d;
  logic [TW-1:0] rt_q, rt_d;
  logic [CW-1:0] rcy_q, rcy_d;
  logic [15:0]   done_q, done_d;
  logic          in_valid;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = i_req_valid && !full;
  assign head_a   = fa_q[rptr_q];
  assign head_b   = fb_q[rptr_q];
  assign head_tag = ft_q[rptr_q];
  assign cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

  // Job storage, written only on an accepted request
  always_ff @(posedge i_clk) begin
    if (push) begin
      fa_q[wptr_q] <= i_req_a;
      fb_q[wptr_q] <= i_req_b;
      ft_q[wptr_q] <= i_req_tag;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (!push && pop)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // Next-state: issue FSM, cycle counter, response slot
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    cyc_d    = cyc_q;
    rv_d     = rv_q;
    rc_d     = rc_q;
    rt_d     = rt_q;
    rcy_d    = rcy_q;
    done_d   = done_q;
    pop      = 1'b0;
    in_valid = 1'b0;

    if (rv_q && i_resp_ready) begin
      rv_d   = 1'b0;
      done_d = done_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (!empty && !rv_q) begin
          pop = 1'b1;
          if (head_a == '0) begin
            rv_d  = 1'b1;
            rc_d  = head_b;
            rt_d  = head_tag;
            rcy_d = '0;
          end else if (head_b == '0) begin
            rv_d  = 1'b1;
            rc_d  = head_a;
            rt_d  = head_tag;
            rcy_d = '0;
          end else begin
            a_d     = head_a;
            b_d     = head_b;
            tag_d   = head_tag;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        in_valid = 1'b1;
        if (i_gcd_in_ready) begin
          cyc_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_gcd_out_valid) begin
          rv_d    = 1'b1;
          rc_d    = i_gcd_c;
          rt_d    = tag_q;
          rcy_d   = cyc_inc;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and data registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      cyc_q   <= '0;
      rv_q    <= 1'b0;
      rc_q    <= '0;
      rt_q    <= '0;
      rcy_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      cyc_q   <= cyc_d;
      rv_q    <= rv_d;
      rc_q    <= rc_d;
      rt_q    <= rt_d;
      rcy_q   <= rcy_d;
      done_q  <= done_d;
    end
  end

  assign o_req_ready    = !full;
  assign o_resp_valid   = rv_q;
  assign o_resp_c       = rc_q;
  assign o_resp_tag     = rt_q;
  assign o_resp_cycles  = rcy_q;
  assign o_done_count   = done_q;
  assign o_busy         = (state_q != IDLE) || !empty;
  assign o_gcd_a        = a_q;
  assign o_gcd_b        = b_q;
  assign o_gcd_in_valid = in_valid;

endmodule

// File: tb/tb_gcd_job_sched.sv
// tb_gcd_job_sched: behavioural GCD core with chosen latency plus
// queue scoreboard of expected responses in request order.
module tb_gcd_job_sched;

  localparam int W  = 16;
  localparam int TW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [W-1:0]  req_a, req_b;
  logic [TW-1:0] req_tag;
  logic          resp_valid, resp_ready;
  logic [W-1:0]  resp_c;
  logic [TW-1:0] resp_tag;
  logic [CW-1:0] resp_cycles;
  logic [15:0]   done_count;
  logic          busy;
  logic [W-1:0]  gcd_a, gcd_b, gcd_c;
  logic          gcd_in_valid, gcd_in_ready, gcd_out_valid;

  always #5 clk = ~clk;

  gcd_job_sched #(.W(W), .TW(TW), .DEPTH(4), .CW(CW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_a        (req_a),
    .i_req_b        (req_b),
    .i_req_tag      (req_tag),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_c       (resp_c),
    .o_resp_tag     (resp_tag),
    .o_resp_cycles  (resp_cycles),
    .o_done_count   (done_count),
    .o_busy         (busy),
    .o_gcd_a        (gcd_a),
    .o_gcd_b        (gcd_b),
    .o_gcd_in_valid (gcd_in_valid),
    .i_gcd_in_ready (gcd_in_ready),
    .i_gcd_out_valid(gcd_out_valid),
    .i_gcd_c        (gcd_c)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 5) == 0) return '0;
    return W'($urandom_range(1, 2000));
  endfunction

  // GCD core model: result pulse in the L-th cycle after load
  logic         cm_busy = 1'b0;
  int           cm_rem = 0;
  logic [W-1:0] cm_res = '0;
  int           cm_lat = 9;
  bit           cm_rand = 1'b0;
  bit           cm_stall = 1'b0;
  int           lat_q[$];

  assign gcd_in_ready  = !cm_busy && !cm_stall;
  assign gcd_out_valid = cm_busy && (cm_rem == 1);
  assign gcd_c         = cm_res;

  always @(posedge clk) begin
    int l;
    if (rst) begin
      cm_busy <= 1'b0;
      cm_rem  <= 0;
    end else if (cm_busy) begin
      if (cm_rem == 1) cm_busy <= 1'b0;
      else cm_rem <= cm_rem - 1;
    end else if (gcd_in_valid && gcd_in_ready) begin
      l = cm_rand ? int'($urandom_range(1, 12)) : cm_lat;
      cm_busy <= 1'b1;
      cm_rem  <= l;
      cm_res  <= gcd_ref(gcd_a, gcd_b);
      lat_q.push_back(l);
    end
  end

  always @(posedge clk) begin
    #1;
    cm_stall = cm_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  bit rnd_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rnd_ready) resp_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard
  typedef struct {
    logic [W-1:0]  c;
    logic [TW-1:0] tag;
    bit            byp;
  } exp_t;

  exp_t          exp_q[$];
  logic [W-1:0]  last_c = '0;
  logic [TW-1:0] last_tag = '0;
  logic [CW-1:0] last_cyc = '0;
  bit            hold_pend = 1'b0;
  logic [W+TW+CW-1:0] held;
  int            iv_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    int   ecyc;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (gcd_in_valid) iv_cnt++;
      if (hold_pend)
        check("hold", {resp_c, resp_tag, resp_cycles}, held);
      hold_pend = resp_valid && !resp_ready;
      held = {resp_c, resp_tag, resp_cycles};
      if (req_valid && req_ready) begin
        e.c   = gcd_ref(req_a, req_b);
        e.tag = req_tag;
        e.byp = (req_a == 0) || (req_b == 0);
        exp_q.push_back(e);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("resp_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.byp) ecyc = 0;
          else if (lat_q.size() > 0) ecyc = lat_q.pop_front();
          else ecyc = -1;
          check("resp_c", resp_c, e.c);
          check("resp_tag", resp_tag, e.tag);
          check("resp_cycles", resp_cycles, CW'(ecyc));
        end
        last_c   = resp_c;
        last_tag = resp_tag;
        last_cyc = resp_cycles;
      end
    end
  end

  task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] t);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_tag   = t;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !resp_valid && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", ok, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    int acc;
    bit dropped;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_in_valid", gcd_in_valid, 0);
    check("rst_gcd_a", gcd_a, 0);
    check("rst_gcd_b", gcd_b, 0);
    check("rst_resp_c", resp_c, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_resp_cycles", resp_cycles, 0);
    check("rst_done", done_count, 0);

    iv_cnt = 0;
    cm_lat = 9;
    push_job(48, 18, 3);
    drain();
    check("t1_iv_cycles", iv_cnt, 1);
    check("t1_c", last_c, 6);
    check("t1_tag", last_tag, 3);
    check("t1_cycles", last_cyc, 9);

    cm_lat = 2;
    push_job(1, 1, 1);
    drain();
    check("t2_c", last_c, 1);
    check("t2_cycles", last_cyc, 2);

    iv_cnt = 0;
    push_job(0, 35, 5);
    drain();
    check("t3a_c", last_c, 35);
    check("t3a_tag", last_tag, 5);
    check("t3a_cycles", last_cyc, 0);
    push_job(35, 0, 6);
    drain();
    check("t3b_c", last_c, 35);
    check("t3b_cycles", last_cyc, 0);
    push_job(0, 0, 7);
    drain();
    check("t3c_c", last_c, 0);
    check("t3_iv_cycles", iv_cnt, 0);
    check("t3_done", done_count, 5);

    base      = done_count;
    cm_rand   = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      push_job(rnd_op(), rnd_op(), TW'(i));
    drain();
    check("t4_done", done_count - base, 8);

    base = done_count;
    for (int i = 0; i < 30; i++)
      push_job(rnd_op(), rnd_op(), TW'($urandom_range(0, 15)));
    drain();
    check("t4b_done", done_count - base, 30);
    rnd_ready = 1'b0;
    cm_rand   = 1'b0;

    cm_lat  = 3;
    acc     = 0;
    dropped = 1'b0;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_a      = W'($urandom_range(1, 999));
    req_b      = W'($urandom_range(1, 999));
    req_tag    = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!req_ready) begin
        dropped = 1'b1;
        break;
      end
      acc++;
      @(posedge clk);
      #1;
      req_a   = W'($urandom_range(1, 999));
      req_b   = W'($urandom_range(1, 999));
      req_tag = TW'(acc);
    end
    check("t5_dropped", dropped, 1);
    check("t5_accepts", acc, 5);
    repeat (3) @(negedge clk);
    check("t5_ready_low", req_ready, 0);
    check("t5_slot_full", resp_valid, 1);
    check("t5_slot_tag", resp_tag, 0);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    base       = done_count;
    resp_ready = 1'b1;
    drain();
    check("t5_done", done_count - base, 5);

    cm_lat = 1000;
    push_job(16'hFFFF, 1, 9);
    repeat (6) @(negedge clk);
    check("t6_busy", busy, 1);
    check("t6_in_valid", gcd_in_valid, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_resp_valid", resp_valid, 0);
    check("t6_req_ready", req_ready, 1);
    check("t6_busy_after", busy, 0);
    check("t6_done", done_count, 0);
    cm_lat = 4;
    push_job(12, 8, 2);
    drain();
    check("t6_c", last_c, 4);
    check("t6_tag", last_tag, 2);
    check("t6_cycles", last_cyc, 4);
    check("t6_done_after", done_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
